// File: rtl/fetch_aligner.sv
// fetch_aligner: halfword realigner between IMEM and the RVC decompressor.
// Define FETCH_ALIGN_ILLEGAL_EN to flag >32-bit length encodings.
module fetch_aligner #(
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] fetch_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_ready_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        instr_illegal_o
);

  localparam int unsigned PW = $clog2(BUF_HW);
  localparam int unsigned CW = $clog2(BUF_HW + 1);

  typedef enum logic {RUN, SKIP} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   q_mem [BUF_HW];
  logic [PW-1:0] head_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   fetch_q;
  logic [31:0]   pc_q;

  logic [PW-1:0] tail0;
  logic [PW-1:0] tail1;
  logic [PW-1:0] h1_idx;
  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is_c;
  logic          push_ok;
  logic          pop_ok;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;

  // Sums never reach 2*BUF_HW while in use, so one subtract wraps them.
  function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
    logic [PW:0] r;
    r = (v >= (PW+1)'(BUF_HW)) ? v - (PW+1)'(BUF_HW) : v;
    return PW'(r);
  endfunction

  assign tail0  = wrap((PW+1)'(head_q) + (PW+1)'(cnt_q));
  assign tail1  = wrap((PW+1)'(tail0) + 1'b1);
  assign h1_idx = wrap((PW+1)'(head_q) + 1'b1);
  assign h0     = q_mem[head_q];
  assign h1     = q_mem[h1_idx];
  assign is_c   = h0[1:0] != 2'b11;

  assign push_ok = mem_valid_i && mem_ready_o;
  assign pop_ok  = instr_valid_o && instr_ready_i;
  assign n_push  = !push_ok ? 2'd0 : (state_q == SKIP) ? 2'd1 : 2'd2;
  assign n_pop   = !pop_ok ? 2'd0 : is_c ? 2'd1 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= RESET_PC[1] ? SKIP : RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redirect_i: state_d = redirect_pc_i[1] ? SKIP : RUN;
      push_ok:    state_d = RUN;
      default:    ;
    endcase
  end

  always_comb begin
    mem_ready_o   = 1'b0;
    instr_valid_o = 1'b0;
    if (!redirect_i) begin
      unique case (state_q)
        RUN:     mem_ready_o = cnt_q <= CW'(BUF_HW - 2);
        SKIP:    mem_ready_o = cnt_q <= CW'(BUF_HW - 1);
        default: mem_ready_o = 1'b0;
      endcase
      instr_valid_o = is_c ? (cnt_q >= CW'(1)) : (cnt_q >= CW'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      cnt_q   <= '0;
      fetch_q <= {RESET_PC[31:2], 2'b00};
      pc_q    <= RESET_PC;
      for (int i = 0; i < BUF_HW; i++)
        q_mem[i] <= '0;
    end else if (redirect_i) begin
      head_q  <= '0;
      cnt_q   <= '0;
      fetch_q <= {redirect_pc_i[31:2], 2'b00};
      pc_q    <= redirect_pc_i;
    end else begin
      if (push_ok) begin
        fetch_q <= fetch_q + 32'd4;
        if (state_q == SKIP) begin
          q_mem[tail0] <= mem_rdata_i[31:16];
        end else begin
          q_mem[tail0] <= mem_rdata_i[15:0];
          q_mem[tail1] <= mem_rdata_i[31:16];
        end
      end
      if (pop_ok) begin
        head_q <= wrap((PW+1)'(head_q) + (PW+1)'(n_pop));
        pc_q   <= pc_q + (is_c ? 32'd2 : 32'd4);
      end
      cnt_q <= cnt_q + CW'(n_push) - CW'(n_pop);
    end
  end

  assign fetch_addr_o = fetch_q;
  assign instr_o      = is_c ? {16'h0000, h0} : {h1, h0};
  assign instr_pc_o   = pc_q;
  assign instr_is_c_o = (cnt_q != '0) && is_c;

`ifdef FETCH_ALIGN_ILLEGAL_EN
  assign instr_illegal_o = instr_valid_o && (h0[4:0] == 5'b11111);
`else
  assign instr_illegal_o = 1'b0;
`endif

endmodule
